// File: rtl/phase_timer_arbiter_if.sv
// Handshake bundle between the light FSMs and the shared phase timer.
// The requesters drive the master side; the timer owns the slave side.
interface phase_timer_arbiter_if #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned CNT_W = 8
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  kind;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  done;
    logic [NREQ-1:0]  abort;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    // Requester side: raises req/kind, watches grant and completion pulses
    modport master (
        output req,
        output kind,
        input  grant,
        input  done,
        input  abort,
        input  busy,
        input  remaining
    );

    // Timer side: samples requests, drives grant and status
    modport slave (
        input  req,
        input  kind,
        output grant,
        output done,
        output abort,
        output busy,
        output remaining
    );
endinterface

// File: rtl/phase_timer_arbiter.sv
// Shared phase countdown timer with round-robin arbitration between light FSMs.
// A requester is granted the timer, the selected green/yellow duration is
// counted down, and the interval ends with a one-cycle done or abort pulse.
// Optional build macro PHASE_TIMER_CFG_EN adds runtime-writable durations
// (cfg_we / cfg_green / cfg_yellow) and a sticky cfg_ro_err flag.
// The interface instance must be parameterised with the same NREQ / CNT_W.
module phase_timer_arbiter #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned GREEN_TICKS  = 25,
    parameter int unsigned YELLOW_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef PHASE_TIMER_CFG_EN
    input  logic                  cfg_we,
    input  logic [CNT_W-1:0]      cfg_green,
    input  logic [CNT_W-1:0]      cfg_yellow,
    output logic                  cfg_ro_err,
`endif
    phase_timer_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Zero durations would load an underflowed count; clamp to one cycle.
    localparam int unsigned G_EFF = (GREEN_TICKS  == 0) ? 1 : GREEN_TICKS;
    localparam int unsigned Y_EFF = (YELLOW_TICKS == 0) ? 1 : YELLOW_TICKS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] owner_q;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [NREQ-1:0]  grant_q;
    logic [NREQ-1:0]  done_q;
    logic [NREQ-1:0]  abort_q;
    logic             busy_q;

    logic [CNT_W-1:0] green_dur;
    logic [CNT_W-1:0] yellow_dur;
    logic [PTR_W-1:0] winner_d;
    logic [CNT_W-1:0] load_d;
    logic [PTR_W-1:0] rr_next_d;

    // First set request at or after ptr, wrapping modulo NREQ
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [NREQ-1:0]  r,
        input logic [PTR_W-1:0] ptr
    );
        logic [PTR_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!found && r[PTR_W'(idx)]) begin
                pick  = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef PHASE_TIMER_CFG_EN
    logic [CNT_W-1:0] green_q;
    logic [CNT_W-1:0] yellow_q;
    logic             cfg_ro_q;

    // Runtime durations: writable only while idle; writes during RUN flag an error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            green_q  <= CNT_W'(G_EFF);
            yellow_q <= CNT_W'(Y_EFF);
            cfg_ro_q <= 1'b0;
        end else if (cfg_we) begin
            if (state_q == IDLE) begin
                green_q  <= (cfg_green  == '0) ? CNT_W'(1) : cfg_green;
                yellow_q <= (cfg_yellow == '0) ? CNT_W'(1) : cfg_yellow;
            end else begin
                cfg_ro_q <= 1'b1;
            end
        end
    end

    assign green_dur  = green_q;
    assign yellow_dur = yellow_q;
    assign cfg_ro_err = cfg_ro_q;
`else
    assign green_dur  = CNT_W'(G_EFF);
    assign yellow_dur = CNT_W'(Y_EFF);
`endif

    // Arbitration winner, count preload and the pointer value after release
    always_comb begin
        winner_d  = rr_pick(bus.req, rr_ptr_q);
        load_d    = bus.kind[winner_d] ? (yellow_dur - CNT_W'(1))
                                       : (green_dur  - CNT_W'(1));
        rr_next_d = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);
    end

    // IDLE/RUN controller; all handshake outputs are registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            abort_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            done_q  <= '0;
            abort_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_q <= RUN;
                        owner_q <= winner_d;
                        grant_q <= NREQ'(1) << winner_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= load_d;
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        // Completion wins over a same-cycle request drop
                        state_q         <= IDLE;
                        grant_q         <= '0;
                        busy_q          <= 1'b0;
                        done_q[owner_q] <= 1'b1;
                        rr_ptr_q        <= rr_next_d;
                    end else if (!bus.req[owner_q]) begin
                        state_q          <= IDLE;
                        grant_q          <= '0;
                        busy_q           <= 1'b0;
                        abort_q[owner_q] <= 1'b1;
                        rr_ptr_q         <= rr_next_d;
                        cnt_q            <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.abort     = abort_q;
    assign bus.busy      = busy_q;
    assign bus.remaining = cnt_q;

endmodule

// File: tb/tb_phase_timer_arbiter.sv
// Bench for phase_timer_arbiter: directed vector table, a round-robin
// sequence, randomized traffic against a reference model, and the optional
// runtime-configuration feature when PHASE_TIMER_CFG_EN is defined.
module tb_phase_timer_arbiter;

    localparam int NREQ   = 2;
    localparam int CNT_W  = 8;
    localparam int GREEN  = 5;
    localparam int YELLOW = 2;

    logic clk;
    logic rst_n;

    phase_timer_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

`ifdef PHASE_TIMER_CFG_EN
    logic             cfg_we;
    logic [CNT_W-1:0] cfg_green;
    logic [CNT_W-1:0] cfg_yellow;
    logic             cfg_ro_err;
`endif

    phase_timer_arbiter #(
        .NREQ        (NREQ),
        .CNT_W       (CNT_W),
        .GREEN_TICKS (GREEN),
        .YELLOW_TICKS(YELLOW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PHASE_TIMER_CFG_EN
        .cfg_we    (cfg_we),
        .cfg_green (cfg_green),
        .cfg_yellow(cfg_yellow),
        .cfg_ro_err(cfg_ro_err),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // Drive inputs, then sample just after the following rising edge
    task automatic apply(input logic r_n, input logic [1:0] r, input logic [1:0] k);
        rst_n    = r_n;
        bus.req  = r;
        bus.kind = k;
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: who holds the timer, for how long, and
    // how many of those cycles have already elapsed.
    int m_busy, m_owner, m_elapsed, m_dur, m_ptr;

    task automatic model_step(input logic r_n, input logic [1:0] r, input logic [1:0] k,
                              output logic [1:0] eg, output logic [1:0] ed,
                              output logic [1:0] ea, output logic eb, output int erem);
        ed = 2'b00;
        ea = 2'b00;
        if (!r_n) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (m_busy == 0) begin
            for (int s = 0; s < NREQ; s++) begin
                int j;
                j = (m_ptr + s) % NREQ;
                if (m_busy == 0 && r[j]) begin
                    m_busy    = 1;
                    m_owner   = j;
                    m_dur     = k[j] ? YELLOW : GREEN;
                    m_elapsed = 0;
                end
            end
        end else if (m_elapsed == m_dur - 1) begin
            m_busy        = 0;
            ed[m_owner]   = 1'b1;
            m_ptr         = (m_owner + 1) % NREQ;
        end else if (!r[m_owner]) begin
            m_busy        = 0;
            ea[m_owner]   = 1'b1;
            m_ptr         = (m_owner + 1) % NREQ;
        end else begin
            m_elapsed++;
        end
        eg   = (m_busy != 0) ? (2'b01 << m_owner) : 2'b00;
        eb   = (m_busy != 0);
        erem = (m_busy != 0) ? (m_dur - 1 - m_elapsed) : 0;
    endtask

    typedef struct {
        logic       rst_n;
        logic [1:0] req;
        logic [1:0] kind;
        logic [1:0] grant;
        logic [1:0] done;
        logic [1:0] abort;
        logic       busy;
        int         rem;
    } vec_t;

    vec_t tbl[25];
    int   rr_grant[10];
    int   rr_done[10];

    initial begin
        logic [1:0] eg, ed, ea, r, k;
        logic       eb, rn;
        int         erem;

        rst_n    = 1'b0;
        bus.req  = 2'b00;
        bus.kind = 2'b00;
`ifdef PHASE_TIMER_CFG_EN
        cfg_we     = 1'b0;
        cfg_green  = '0;
        cfg_yellow = '0;
`endif

        // rst_n, req, kind -> grant, done, abort, busy, remaining
        tbl[0]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0};
        tbl[1]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0};
        tbl[2]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0};
        tbl[3]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0};
        tbl[4]  = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 4};
        tbl[5]  = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 3};
        tbl[6]  = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 2};
        tbl[7]  = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1};
        tbl[8]  = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 0};
        tbl[9]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 0};
        tbl[10] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0};
        tbl[11] = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 4};
        tbl[12] = '{1'b1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 3};
        tbl[13] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 0};
        tbl[14] = '{1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 1};
        tbl[15] = '{1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 0};
        tbl[16] = '{1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 0};
        tbl[17] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0};
        tbl[18] = '{1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1};
        tbl[19] = '{1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 0};
        tbl[20] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 0};
        tbl[21] = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 4};
        tbl[22] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0};
        tbl[23] = '{1'b1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 4};
        tbl[24] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0};

        // Continuous req=11, kind=10: green owner 0, gap, yellow owner 1, gap, owner 0
        rr_grant = '{1, 1, 1, 1, 1, 0, 2, 2, 0, 1};
        rr_done  = '{0, 0, 0, 0, 0, 1, 0, 0, 2, 0};

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i].rst_n, tbl[i].req, tbl[i].kind);
            check($sformatf("vec%0d_grant", i), int'(bus.grant), int'(tbl[i].grant));
            check($sformatf("vec%0d_done", i),  int'(bus.done),  int'(tbl[i].done));
            check($sformatf("vec%0d_abort", i), int'(bus.abort), int'(tbl[i].abort));
            check($sformatf("vec%0d_busy", i),  int'(bus.busy),  int'(tbl[i].busy));
            check($sformatf("vec%0d_rem", i),   int'(bus.remaining), tbl[i].rem);
        end

        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 2'b11, 2'b10);
            check($sformatf("rr%0d_grant", i), int'(bus.grant), rr_grant[i]);
            check($sformatf("rr%0d_done", i),  int'(bus.done),  rr_done[i]);
        end

        // Randomized traffic: sticky requests with occasional drops and resets
        r = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            rn = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            k = 2'($urandom_range(0, 3));
            apply(rn, r, k);
            model_step(rn, r, k, eg, ed, ea, eb, erem);
            check("rnd_grant", int'(bus.grant), int'(eg));
            check("rnd_done",  int'(bus.done),  int'(ed));
            check("rnd_abort", int'(bus.abort), int'(ea));
            check("rnd_busy",  int'(bus.busy),  int'(eb));
            check("rnd_rem",   int'(bus.remaining), erem);
            check("rnd_done_abort_excl", int'((bus.done & bus.abort) != 0), 0);
            check("rnd_pulse_vs_grant",  int'(((bus.done | bus.abort) != 0) && (bus.grant != 0)), 0);
        end

`ifdef PHASE_TIMER_CFG_EN
        begin
            int n;
            apply(1'b0, 2'b00, 2'b00);
            apply(1'b1, 2'b00, 2'b00);
            check("cfg_ro_err_reset", int'(cfg_ro_err), 0);
            cfg_we = 1'b1; cfg_green = 8'd3; cfg_yellow = 8'd0;
            apply(1'b1, 2'b00, 2'b00);
            cfg_we = 1'b0;
            for (int t = 0; t < 3; t++) begin
                n = 0;
                rst_n = 1'b1; bus.req = 2'b01; bus.kind = (t == 1) ? 2'b01 : 2'b00;
                cfg_green = 8'd9; cfg_yellow = 8'd9;
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk); #1;
                    if (bus.grant != 0) begin
                        n++;
                        cfg_we = (t == 1);
                    end
                    if (bus.done != 0) break;
                end
                cfg_we = 1'b0;
                check($sformatf("cfg_len%0d", t), n, (t == 1) ? 1 : 3);
                apply(1'b1, 2'b00, 2'b00);
                apply(1'b1, 2'b00, 2'b00);
            end
            check("cfg_ro_err_set", int'(cfg_ro_err), 1);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
